// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
//   arb_state_e          : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   DefaultTimeoutCycles : default WAIT-state timeout
package sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

    localparam int unsigned DefaultTimeoutCycles = 16;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin pick.
//   req[1:0]   : request vector (bit i = master i valid)
//   last_grant : master granted most recently
//   winner     : index of the master to grant (meaningful only when req != 0)
module sram_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

    always_comb begin
        winner = last_grant;
        unique case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = last_grant;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of a single-port SRAM with one-cycle latency.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs registered.
//   m0_* / m1_*     : master request channels (valid/instr/addr/wdata/wstrb in, ready/rdata out)
//   s_*             : SRAM request channel (valid/instr/addr/wdata/wstrb out, ready/rdata in)
//   busy            : FSM not in IDLE
//   grant           : master owning the current or last transaction
//   timeout_err     : sticky, set when WAIT exceeded TIMEOUT_CYCLES; cleared only by reset
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        busy,
    output logic        grant,
    output logic        timeout_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    arb_state_e state_q, state_d;

    logic            last_grant_q, last_grant_d;
    logic            grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            s_valid_q, s_valid_d;
    logic            s_instr_q, s_instr_d;
    logic [31:0]     s_addr_q, s_addr_d;
    logic [31:0]     s_wdata_q, s_wdata_d;
    logic [3:0]      s_wstrb_q, s_wstrb_d;
    logic            m0_ready_q, m0_ready_d;
    logic            m1_ready_q, m1_ready_d;
    logic [31:0]     m0_rdata_q, m0_rdata_d;
    logic [31:0]     m1_rdata_q, m1_rdata_d;
    logic            timeout_err_q, timeout_err_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [1:0] req;
    logic       winner;
    logic       timeout_hit;

    assign req         = {m1_valid, m0_valid};
    // cnt_q counts completed WAIT cycles; this is the last allowed one.
    assign timeout_hit = (cnt_q == CntLast);

    sram_arb_rr2 u_rr2 (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (winner)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (s_ready || timeout_hit) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        busy_d        = (state_d != StIdle);
        s_valid_d     = 1'b0;
        s_instr_d     = s_instr_q;
        s_addr_d      = s_addr_q;
        s_wdata_d     = s_wdata_q;
        s_wstrb_d     = s_wstrb_q;
        m0_ready_d    = 1'b0;
        m1_ready_d    = 1'b0;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    s_valid_d    = 1'b1;
                    s_instr_d    = winner ? m1_instr : m0_instr;
                    s_addr_d     = winner ? m1_addr  : m0_addr;
                    s_wdata_d    = winner ? m1_wdata : m0_wdata;
                    s_wstrb_d    = winner ? m1_wstrb : m0_wstrb;
                end
            end
            StIssue: begin
                cnt_d = '0;
            end
            StWait: begin
                if (s_ready || timeout_hit) begin
                    // A timed-out access returns zero data to the requester.
                    if (grant_q) begin
                        m1_rdata_d = s_ready ? s_rdata : 32'h0;
                        m1_ready_d = 1'b1;
                    end else begin
                        m0_rdata_d = s_ready ? s_rdata : 32'h0;
                        m0_ready_d = 1'b1;
                    end
                    if (!s_ready) timeout_err_d = 1'b1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            busy_q        <= 1'b0;
            s_valid_q     <= 1'b0;
            s_instr_q     <= 1'b0;
            s_addr_q      <= 32'h0;
            s_wdata_q     <= 32'h0;
            s_wstrb_q     <= 4'h0;
            m0_ready_q    <= 1'b0;
            m1_ready_q    <= 1'b0;
            m0_rdata_q    <= 32'h0;
            m1_rdata_q    <= 32'h0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            s_valid_q     <= s_valid_d;
            s_instr_q     <= s_instr_d;
            s_addr_q      <= s_addr_d;
            s_wdata_q     <= s_wdata_d;
            s_wstrb_q     <= s_wstrb_d;
            m0_ready_q    <= m0_ready_d;
            m1_ready_q    <= m1_ready_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign s_valid     = s_valid_q;
    assign s_instr     = s_instr_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_wstrb     = s_wstrb_q;
    assign m0_ready    = m0_ready_q;
    assign m1_ready    = m1_ready_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign busy        = busy_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: sram_arbiter paired with a one-cycle-latency SRAM model.
module tb_sram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        busy, grant, timeout_err;

    int errors = 0;
    int checks = 0;
    bit sram_mute = 0;

    logic [31:0] mem [0:255];

    sram_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_valid    (m0_valid),
        .m0_instr    (m0_instr),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wstrb    (m0_wstrb),
        .m0_ready    (m0_ready),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_instr    (m1_instr),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wstrb    (m1_wstrb),
        .m1_ready    (m1_ready),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_instr     (s_instr),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .busy        (busy),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // SRAM model: accepts s_valid, answers one cycle later with the merged word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready <= 1'b0;
            s_rdata <= 32'h0;
        end else begin
            s_ready <= s_valid && !sram_mute;
            if (s_valid) begin
                s_rdata           <= merge(mem[s_addr[9:2]], s_wdata, s_wstrb);
                mem[s_addr[9:2]]  <= merge(mem[s_addr[9:2]], s_wdata, s_wstrb);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_s_valid"}, 32'(s_valid), 0);
        check_eq({tag, "_s_instr"}, 32'(s_instr), 0);
        check_eq({tag, "_s_addr"}, s_addr, 0);
        check_eq({tag, "_s_wdata"}, s_wdata, 0);
        check_eq({tag, "_s_wstrb"}, 32'(s_wstrb), 0);
        check_eq({tag, "_readys"}, 32'({m0_ready, m1_ready}), 0);
        check_eq({tag, "_m0_rdata"}, m0_rdata, 0);
        check_eq({tag, "_m1_rdata"}, m1_rdata, 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_grant"}, 32'(grant), 0);
        check_eq({tag, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    // Single-master transaction; called and returns at a negedge.
    task automatic run_txn(input string tag, input int m, input logic instr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                           input int exp_lat);
        int lat;
        bit seen;
        bit other;
        lat = 0; seen = 0; other = 0;
        if (m == 0) begin
            m0_valid = 1; m0_instr = instr; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
        end else begin
            m1_valid = 1; m1_instr = instr; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
        end
        while (!seen && lat < 40) begin
            tick();
            lat++;
            if (lat == 1) begin
                check_eq({tag, "_issue_svalid"}, 32'(s_valid), 1);
                check_eq({tag, "_issue_payload"}, s_addr ^ s_wdata, addr ^ wdata);
                check_eq({tag, "_issue_ctl"}, 32'({s_instr, s_wstrb}), 32'({instr, wstrb}));
            end
            if (lat == 2) check_eq({tag, "_wait_svalid"}, 32'(s_valid), 0);
            if ((m == 0) ? m1_ready : m0_ready) other = 1;
            if ((m == 0) ? m0_ready : m1_ready) seen = 1;
        end
        check_eq({tag, "_seen"}, 32'(seen), 1);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_rdata"}, (m == 0) ? m0_rdata : m1_rdata, exp_rdata);
        check_eq({tag, "_grant"}, 32'(grant), m);
        check_eq({tag, "_other_ready"}, 32'(other), 0);
        m0_valid = 0;
        m1_valid = 0;
        tick();
        check_eq({tag, "_pulse_end"}, 32'({m0_ready, m1_ready}), 0);
        check_eq({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        m0_valid = 0;
        m1_valid = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        int t0, t1, g0, g1, cyc, n, rdy_cnt;
        logic [31:0] d0, d1;
        int seq [4];

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n = 0;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        @(negedge clk);
        tick();
        check_all_zero("reset");
        rst_n = 1;
        tick();

        // Basic write / read-back on m0, instruction fetch qualifier on the read.
        run_txn("m0_wr", 0, 1'b0, 32'h10, 32'hA5A5_1234, 4'hF, 32'hA5A5_1234, 3);
        run_txn("m0_rd", 0, 1'b1, 32'h10, 32'h0, 4'h0, 32'hA5A5_1234, 3);

        // Byte-lane merge on m1.
        run_txn("m1_pre", 1, 1'b0, 32'h20, 32'h1122_3344, 4'hF, 32'h1122_3344, 3);
        run_txn("m1_byte", 1, 1'b0, 32'h20, 32'h0000_EE00, 4'h2, 32'h1122_EE44, 3);

        // Contention on a fresh reset: m0 first, m1 four cycles later.
        do_reset();
        m0_valid = 1; m0_instr = 0; m0_addr = 32'h10; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 1; m1_instr = 0; m1_addr = 32'h20; m1_wdata = 0; m1_wstrb = 0;
        t0 = -1; t1 = -1; g0 = -1; g1 = -1; d0 = 0; d1 = 0; cyc = 0;
        while ((t0 < 0 || t1 < 0) && cyc < 30) begin
            tick();
            cyc++;
            if (m0_ready) begin t0 = cyc; g0 = int'(grant); d0 = m0_rdata; m0_valid = 0; end
            if (m1_ready) begin t1 = cyc; g1 = int'(grant); d1 = m1_rdata; m1_valid = 0; end
        end
        check_eq("cont_m0_lat", t0, 3);
        check_eq("cont_m0_grant", g0, 0);
        check_eq("cont_m0_rdata", d0, 32'hA5A5_1234);
        check_eq("cont_m1_lat", t1, 7);
        check_eq("cont_m1_grant", g1, 1);
        check_eq("cont_m1_rdata", d1, 32'h1122_EE44);
        m0_valid = 0; m1_valid = 0;
        tick();

        // Both masters keep requesting: grants alternate.
        m0_valid = 1; m1_valid = 1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (m0_ready) begin
                seq[n] = 0; n++; m0_valid = 0;
                check_eq("alt_m0_rdata", m0_rdata, 32'hA5A5_1234);
            end else if (!m0_valid) m0_valid = 1;
            if (m1_ready) begin
                seq[n] = 1; n++; m1_valid = 0;
                check_eq("alt_m1_rdata", m1_rdata, 32'h1122_EE44);
            end else if (!m1_valid) m1_valid = 1;
        end
        m0_valid = 0; m1_valid = 0;
        check_eq("alt_count", n, 4);
        if (n == 4) check_eq("alt_seq", 32'({seq[0][0], seq[1][0], seq[2][0], seq[3][0]}),
                             32'b0101);
        tick();
        tick();

        // SRAM silent: forced zero response after 16 WAIT cycles.
        check_eq("to_err_before", 32'(timeout_err), 0);
        sram_mute = 1;
        run_txn("timeout", 0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 18);
        check_eq("to_err_set", 32'(timeout_err), 1);
        tick();
        tick();
        check_eq("to_err_sticky", 32'(timeout_err), 1);

        // Reset while parked in WAIT.
        m1_valid = 1; m1_instr = 0; m1_addr = 32'h10; m1_wdata = 0; m1_wstrb = 0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("midrst_busy", 32'(busy), 1);
        rst_n = 0;
        m1_valid = 0;
        #1;
        check_all_zero("midrst");
        #2;
        rst_n = 1;
        sram_mute = 0;
        rdy_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (m0_ready || m1_ready) rdy_cnt++;
        end
        check_eq("midrst_no_ready", rdy_cnt, 0);
        run_txn("post_rst", 1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hA5A5_1234, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
